// File: rtl/ftq_commit_queue.sv
// Fetch target queue: holds BPU-predicted fetch blocks, hands them to the IFU
// in order, retires them on backend commit and produces BPU training updates.
module ftq_commit_queue #(
    parameter int unsigned FTQ_SIZE     = 8,
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter int unsigned ADDR_WIDTH   = 32
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    // BPU enqueue
    input  logic                                      bpu_valid_i,
    output logic                                      bpu_ready_o,
    input  logic [ADDR_WIDTH-1:0]                     bpu_start_pc_i,
    input  logic [2:0]                                bpu_length_i,
    input  logic                                      bpu_taken_i,
    input  logic [ADDR_WIDTH-1:0]                     bpu_target_i,
    // IFU read
    output logic                                      ifu_valid_o,
    input  logic                                      ifu_ready_i,
    output logic [ADDR_WIDTH-1:0]                     ifu_start_pc_o,
    output logic [2:0]                                ifu_length_o,
    output logic [$clog2(FTQ_SIZE)-1:0]               ifu_ftq_id_o,
    // Backend commit / flush
    input  logic [COMMIT_WIDTH-1:0]                   backend_commit_block_i,
    input  logic                                      backend_flush_i,
    input  logic [$clog2(FTQ_SIZE)-1:0]               backend_flush_ftq_id_i,
    // BPU training
    output logic [COMMIT_WIDTH-1:0]                   bpu_update_valid_o,
    output logic [COMMIT_WIDTH-1:0][ADDR_WIDTH-1:0]   bpu_update_pc_o,
    output logic [COMMIT_WIDTH-1:0]                   bpu_update_taken_o,
    output logic                                      flush_mismatch_o
);

    localparam int unsigned PW = $clog2(FTQ_SIZE);
    // Counters must represent FTQ_SIZE itself, hence one extra bit.
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] start_pc;
        logic [2:0]            length;
        logic                  taken;
        logic [ADDR_WIDTH-1:0] target;
    } entry_t;

    entry_t        entries [FTQ_SIZE];

    logic [PW-1:0] comm_ptr, ifu_ptr, bpu_ptr;
    logic [PW-1:0] comm_ptr_next, ifu_ptr_next, bpu_ptr_next;
    logic [CW-1:0] count, count_next;
    logic [CW-1:0] unread, unread_next;
    logic          mismatch, mismatch_next;

    logic [COMMIT_WIDTH-1:0]                 upd_valid_next;
    logic [COMMIT_WIDTH-1:0][ADDR_WIDTH-1:0] upd_pc_next;
    logic [COMMIT_WIDTH-1:0]                 upd_taken_next;

    logic          enq, ifu_fire;
    logic [CW-1:0] n_commit;
    logic [CW:0]   count_sum;
    logic [PW-1:0] comm_adv, flush_tgt;

    assign bpu_ready_o    = (count != CW'(FTQ_SIZE));
    // The unread counter disambiguates the full-queue case where ifu_ptr == bpu_ptr.
    assign ifu_valid_o    = (unread != '0);
    assign ifu_start_pc_o = entries[ifu_ptr].start_pc;
    assign ifu_length_o   = entries[ifu_ptr].length;
    assign ifu_ftq_id_o   = ifu_ptr;

    assign enq      = bpu_valid_i && bpu_ready_o && !backend_flush_i;
    assign ifu_fire = ifu_valid_o && ifu_ready_i && !backend_flush_i;

    // Commit count, pointer/counter next state and flush handling.
    always_comb begin
        n_commit = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            n_commit = n_commit + CW'(backend_commit_block_i[k]);
        end

        comm_adv  = comm_ptr + PW'(n_commit);
        flush_tgt = backend_flush_ftq_id_i + PW'(1);

        // Over-commit is illegal; saturate instead of wrapping below zero.
        count_sum = {1'b0, count} + (CW + 1)'(enq);
        if (count_sum < {1'b0, n_commit}) begin
            count_next = '0;
        end else begin
            count_next = CW'(count_sum - {1'b0, n_commit});
        end

        unread_next   = unread + CW'(enq) - CW'(ifu_fire);
        comm_ptr_next = comm_adv;
        ifu_ptr_next  = ifu_ptr + PW'(ifu_fire);
        bpu_ptr_next  = bpu_ptr + PW'(enq);
        mismatch_next = mismatch;

        if (backend_flush_i) begin
            comm_ptr_next = flush_tgt;
            ifu_ptr_next  = flush_tgt;
            bpu_ptr_next  = flush_tgt;
            count_next    = '0;
            unread_next   = '0;
            if (comm_adv != flush_tgt) begin
                mismatch_next = 1'b1;
            end
        end
    end

    // Training data: set commit bits are packed in slot order from comm_ptr.
    always_comb begin
        logic [PW-1:0] idx;
        idx            = comm_ptr;
        upd_valid_next = backend_commit_block_i;
        upd_pc_next    = '0;
        upd_taken_next = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (backend_commit_block_i[k]) begin
                upd_pc_next[k]    = entries[idx].start_pc;
                upd_taken_next[k] = entries[idx].taken;
                idx               = idx + PW'(1);
            end
        end
    end

    // Control state and registered training outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comm_ptr           <= '0;
            ifu_ptr            <= '0;
            bpu_ptr            <= '0;
            count              <= '0;
            unread             <= '0;
            mismatch           <= 1'b0;
            bpu_update_valid_o <= '0;
            bpu_update_pc_o    <= '0;
            bpu_update_taken_o <= '0;
        end else begin
            comm_ptr           <= comm_ptr_next;
            ifu_ptr            <= ifu_ptr_next;
            bpu_ptr            <= bpu_ptr_next;
            count              <= count_next;
            unread             <= unread_next;
            mismatch           <= mismatch_next;
            bpu_update_valid_o <= upd_valid_next;
            bpu_update_pc_o    <= upd_pc_next;
            bpu_update_taken_o <= upd_taken_next;
        end
    end

    assign flush_mismatch_o = mismatch;

    // Entry storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries[bpu_ptr] <= '{start_pc: bpu_start_pc_i, length: bpu_length_i,
                                  taken: bpu_taken_i, target: bpu_target_i};
        end
    end

endmodule
